counter_sched: RTL and testbench
================================

Name:
counter_sched

Overview:
Controller that sequences the 8-bit up-counter datapath (clk/reset/preset/load_value/count interface). It loads a start value, gates counting with a programmable prescaler, and detects a terminal value. It then either stops (one-shot) or reloads (periodic), and reports match pulses, a sticky interrupt and a period tally. It sits between the configuration/register logic and the counter instance.

Parameters:
WIDTH, 8, counter datapath width (matches the counter's load_value/count).
PRE_W, 16, prescaler width.

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
start  in  1  pulse; begin a run (accepted in IDLE or DONE only)
stop  in  1  pulse; abort a run (LOAD or RUN)
periodic  in  1  1 = auto-reload at terminal, 0 = one-shot; sampled on start
start_value  in  WIDTH  counter load value; sampled on start
end_value  in  WIDTH  terminal value; sampled on start
prescale  in  PRE_W  counter advances once per prescale+1 cycles; sampled on start
irq_clear  in  1  clears irq
cnt_count  in  WIDTH  count output from counter datapath
cnt_reset  out  1  to counter reset
cnt_preset  out  1  to counter preset
cnt_load_value  out  WIDTH  to counter load_value
busy  out  1  high in LOAD/RUN
match  out  1  one-cycle pulse per terminal event
irq  out  1  sticky terminal flag
period_count  out  8  completed periods since start, saturating at 255

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- The counter increments every clk unless reset or preset is asserted. To hold the counter, the controller drives cnt_preset=1 with cnt_load_value=cnt_count.
- cnt_reset, cnt_preset and cnt_load_value are combinational from state, shadow registers and cnt_count.
- cnt_reset equals the reset input. It is 0 otherwise.
- Under reset: state goes to IDLE. busy=0, match=0, irq=0, period_count=0, prescaler counter=0, shadow registers=0. The counter clears to 0 via cnt_reset.
- Reset mid-run has the same effect: the run is abandoned with no match.
- States: IDLE, LOAD, RUN, DONE. The state register is the only source of busy.
- IDLE: hold the counter. On start, latch periodic, start_value, end_value and prescale into shadow registers, clear period_count, then go to LOAD.
- LOAD (exactly 1 cycle): cnt_preset=1, cnt_load_value=start shadow, prescaler counter<=0, then go to RUN.
- RUN, hold cycle: when prescaler counter != prescale shadow, hold the counter and increment the prescaler counter.
- RUN, advance cycle: when prescaler counter == prescale shadow, the prescaler counter resets to 0.
  - If cnt_count != end shadow: cnt_preset=0, so the counter increments.
  - If cnt_count == end shadow, this is a terminal event:
    - periodic: preset to the start shadow, period_count+1 (saturating), stay in RUN.
    - one-shot: hold the counter, go to DONE.
- Terminal event outputs: match=1 and irq set on the edge closing the event cycle, so they are visible the following cycle. match drops after 1 cycle.
- DONE: hold the counter, so the count stays at end_value. busy=0. start behaves as in IDLE. stop is ignored.
- Arithmetic: the count wraps modulo 2^WIDTH.
  - If end_value < start_value, the counter wraps through 255 to 0 before matching.
  - Period = ((end-start) mod 2^WIDTH + 1) advances × (prescale+1) cycles.
  - end==start gives a match on the first advance.
- stop in LOAD/RUN: go to IDLE next edge. The counter holds its current value (in LOAD: its pre-load value). No match, irq unchanged.
- Simultaneous events:
  - stop and start together: stop wins. From IDLE/DONE both are ignored.
  - start in LOAD/RUN is ignored; there is no restart.
  - irq_clear together with a terminal event: set wins, irq stays 1.
  - start does not clear irq.
- Config inputs changing during RUN have no effect until the next start.

Test Plan:
- Reset → cnt_reset=1, count=0, busy=0, irq=0, match=0, period_count=0; after release the count holds at 0 in IDLE for 10 cycles.
- One-shot: start_value=10, end_value=12, prescale=0, start pulse at cycle 0.
  - Count 10 at cycle 2, 11 at cycle 3, 12 at cycle 4.
  - match=1, irq=1, busy=0 at cycle 5.
  - Count stays 12 thereafter.
- Periodic with prescale: start_value=3, end_value=5, prescale=2.
  - Count changes every 3 cycles: 3,4,5,3,4,5…
  - match pulses every 9 cycles; period_count increments per match; busy stays 1.
- Wrap: start_value=254, end_value=1, one-shot, prescale=0 → sequence 254,255,0,1, then match and DONE with count=1.
- Aborts:
  - stop during RUN at count 7 → IDLE, count holds 7, no match.
  - start+stop in the same cycle in RUN → stop wins.
  - start during RUN → ignored.
- irq and saturation:
  - irq_clear coincident with match → irq remains 1.
  - irq_clear alone → irq=0.
  - periodic run with end==start for 300 advances → period_count saturates at 255.
  - reset asserted mid-RUN → IDLE, count 0.

Source files
------------

// File: rtl/counter_sched.sv
// counter_sched
//
// Sequencing controller for an external 8-bit up-counter datapath. The
// counter increments every clock unless it is reset or preset. To hold it,
// this block presets it with its own current value.
//
// A run works as follows:
//   - The counter is loaded with a start value.
//   - The prescaler lets the counter advance once every prescale+1 cycles.
//   - When the counter reaches the terminal value, a one-shot run stops
//     and a periodic run reloads the start value.
//   - Each terminal event produces a one-cycle match pulse, sets a sticky
//     irq and bumps a saturating period tally.
//
// Ports:
//   clk, reset      - system clock, synchronous active-high reset
//   start, stop     - run control pulses (stop wins when both are high)
//   periodic        - 1 = auto-reload at terminal, 0 = one-shot
//   start_value     - counter load value, captured on an accepted start
//   end_value       - terminal value, captured on an accepted start
//   prescale        - advance every prescale+1 cycles, captured on start
//   irq_clear       - clears irq (a coincident terminal event wins)
//   cnt_count       - current count from the counter datapath
//   cnt_reset       - counter reset (mirrors reset)
//   cnt_preset      - counter preset enable
//   cnt_load_value  - counter preset value
//   busy            - high while loading or running
//   match           - one-cycle pulse after each terminal event
//   irq             - sticky terminal flag
//   period_count    - completed periods since start, saturating at 255
module counter_sched #(
    parameter int WIDTH = 8,
    parameter int PRE_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [WIDTH-1:0] start_value,
    input  logic [WIDTH-1:0] end_value,
    input  logic [PRE_W-1:0] prescale,
    input  logic             irq_clear,
    input  logic [WIDTH-1:0] cnt_count,
    output logic             cnt_reset,
    output logic             cnt_preset,
    output logic [WIDTH-1:0] cnt_load_value,
    output logic             busy,
    output logic             match,
    output logic             irq,
    output logic [7:0]       period_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               periodic_q, periodic_d;
    logic [WIDTH-1:0]   start_q, start_d;
    logic [WIDTH-1:0]   end_q, end_d;
    logic [PRE_W-1:0]   prescale_q, prescale_d;
    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic               match_q, match_d;
    logic               irq_q, irq_d;
    logic [7:0]         period_count_q, period_count_d;

    logic               start_accept;
    logic               advance;
    logic               terminal;

    // A new run may only begin from an idle or finished state.
    // A simultaneous stop cancels the start.
    assign start_accept = start && !stop && (state_q == IDLE || state_q == DONE);

    // Prescaler has expired this cycle, so the counter may move.
    // A stop in the same cycle suppresses both the advance and any
    // terminal event.
    assign advance  = (state_q == RUN) && !stop && (pre_cnt_q == prescale_q);
    assign terminal = advance && (cnt_count == end_q);

    // State register and all other flops.
    // Reset abandons any run with no match.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            periodic_q     <= 1'b0;
            start_q        <= '0;
            end_q          <= '0;
            prescale_q     <= '0;
            pre_cnt_q      <= '0;
            match_q        <= 1'b0;
            irq_q          <= 1'b0;
            period_count_q <= '0;
        end else begin
            state_q        <= state_d;
            periodic_q     <= periodic_d;
            start_q        <= start_d;
            end_q          <= end_d;
            prescale_q     <= prescale_d;
            pre_cnt_q      <= pre_cnt_d;
            match_q        <= match_d;
            irq_q          <= irq_d;
            period_count_q <= period_count_d;
        end
    end

    // Next-state logic and the shadow/prescaler/status updates.
    always_comb begin
        state_d        = state_q;
        periodic_d     = periodic_q;
        start_d        = start_q;
        end_d          = end_q;
        prescale_d     = prescale_q;
        pre_cnt_d      = pre_cnt_q;
        match_d        = 1'b0;
        irq_d          = irq_q && !irq_clear;
        period_count_d = period_count_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_accept) begin
                    periodic_d     = periodic;
                    start_d        = start_value;
                    end_d          = end_value;
                    prescale_d     = prescale;
                    period_count_d = '0;
                    state_d        = LOAD;
                end
            end
            LOAD: begin
                pre_cnt_d = '0;
                state_d   = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (!advance) begin
                    pre_cnt_d = pre_cnt_q + 1'b1;
                end else begin
                    pre_cnt_d = '0;
                    if (terminal) begin
                        match_d = 1'b1;
                        irq_d   = 1'b1;
                        if (periodic_q) begin
                            if (period_count_q != 8'hFF) begin
                                period_count_d = period_count_q + 8'd1;
                            end
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter control outputs.
    // The default is to hold the count by presetting it with itself.
    // Only a non-terminal advance releases the preset so the counter can
    // increment.
    always_comb begin
        cnt_reset      = reset;
        cnt_preset     = 1'b1;
        cnt_load_value = cnt_count;

        case (state_q)
            LOAD: begin
                if (!stop) begin
                    cnt_load_value = start_q;
                end
            end
            RUN: begin
                if (advance) begin
                    if (!terminal) begin
                        cnt_preset = 1'b0;
                    end else if (periodic_q) begin
                        cnt_load_value = start_q;
                    end
                end
            end
            default: begin
                cnt_preset     = 1'b1;
                cnt_load_value = cnt_count;
            end
        endcase
    end

    assign busy         = (state_q == LOAD) || (state_q == RUN);
    assign match        = match_q;
    assign irq          = irq_q;
    assign period_count = period_count_q;

endmodule

// File: tb/tb_counter_sched.sv
// Testbench for counter_sched.
// Includes a behavioural model of the 8-bit up-counter datapath so that the
// controller drives a real count. Directed scenarios use hand-computed
// expected values.
module tb_counter_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        periodic = 1'b0;
    logic [7:0]  start_value = 8'd0;
    logic [7:0]  end_value = 8'd0;
    logic [15:0] prescale = 16'd0;
    logic        irq_clear = 1'b0;
    logic [7:0]  cnt_count;
    logic        cnt_reset;
    logic        cnt_preset;
    logic [7:0]  cnt_load_value;
    logic        busy;
    logic        match;
    logic        irq;
    logic [7:0]  period_count;

    int n_compared = 0;
    int n_mismatched = 0;

    counter_sched #(.WIDTH(8), .PRE_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .periodic       (periodic),
        .start_value    (start_value),
        .end_value      (end_value),
        .prescale       (prescale),
        .irq_clear      (irq_clear),
        .cnt_count      (cnt_count),
        .cnt_reset      (cnt_reset),
        .cnt_preset     (cnt_preset),
        .cnt_load_value (cnt_load_value),
        .busy           (busy),
        .match          (match),
        .irq            (irq),
        .period_count   (period_count)
    );

    always #5 clk = ~clk;

    // Counter datapath model: reset clears, preset loads, otherwise it
    // increments and wraps.
    always @(posedge clk) begin
        if (cnt_reset)       cnt_count <= 8'd0;
        else if (cnt_preset) cnt_count <= cnt_load_value;
        else                 cnt_count <= cnt_count + 8'd1;
    end

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start pulse with the given configuration.
    // On return the bench is in cycle 1 (LOAD).
    task automatic pulse_start(input logic per, input logic [7:0] sv,
                               input logic [7:0] ev, input logic [15:0] ps);
        periodic = per; start_value = sv; end_value = ev; prescale = ps;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_compared++; if (cnt_reset !== 1'b1) begin n_mismatched++; $display("[TB] FAIL reset_cnt_reset: got %b want 1", cnt_reset); end
        n_compared++; if (cnt_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_count: got %0d want 0", cnt_count); end
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_compared++; if (irq !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
        n_compared++; if (match !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_match: got %b want 0", match); end
        n_compared++; if (period_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL reset_period: got %0d want 0", period_count); end
        reset = 1'b0;
        #1;
        n_compared++; if (cnt_reset !== 1'b0) begin n_mismatched++; $display("[TB] FAIL release_cnt_reset: got %b want 0", cnt_reset); end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_compared++; if (cnt_count !== 8'd0 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL idle_hold[%0d]: count %0d busy %b want 0/0", i, cnt_count, busy); end
        end
    endtask

    task automatic test_one_shot();
        logic [7:0] exp_cnt [2:4];
        exp_cnt[2] = 8'd10; exp_cnt[3] = 8'd11; exp_cnt[4] = 8'd12;
        pulse_start(1'b0, 8'd10, 8'd12, 16'd0);
        n_compared++; if (busy !== 1'b1 || cnt_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL oneshot_load: busy %b count %0d want 1/0", busy, cnt_count); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            n_compared++; if (cnt_count !== exp_cnt[c] || match !== 1'b0 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL oneshot_c%0d: count %0d match %b busy %b want %0d/0/1", c, cnt_count, match, busy, exp_cnt[c]); end
        end
        tick();
        n_compared++; if (match !== 1'b1 || irq !== 1'b1 || busy !== 1'b0 || cnt_count !== 8'd12) begin n_mismatched++; $display("[TB] FAIL oneshot_match: match %b irq %b busy %b count %0d want 1/1/0/12", match, irq, busy, cnt_count); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_compared++; if (match !== 1'b0 || cnt_count !== 8'd12) begin n_mismatched++; $display("[TB] FAIL oneshot_done[%0d]: match %b count %0d want 0/12", i, match, cnt_count); end
        end
    endtask

    task automatic test_periodic_prescale();
        logic [7:0] ec, ep;
        logic       em;
        pulse_start(1'b1, 8'd3, 8'd5, 16'd2);
        n_compared++; if (period_count !== 8'd0) begin n_mismatched++; $display("[TB] FAIL periodic_clear: period %0d want 0", period_count); end
        for (int c = 2; c <= 29; c++) begin
            tick();
            ec = 8'(3 + ((c - 2) / 3) % 3);
            em = (c >= 11) && ((c - 2) % 9 == 0);
            ep = 8'((c - 2) / 9);
            n_compared++; if (cnt_count !== ec || match !== em || period_count !== ep || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL periodic_c%0d: count %0d match %b period %0d busy %b want %0d/%b/%0d/1", c, cnt_count, match, period_count, busy, ec, em, ep); end
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_compared++; if (busy !== 1'b0 || cnt_count !== 8'd3 || match !== 1'b0) begin n_mismatched++; $display("[TB] FAIL periodic_stop: busy %b count %0d match %b want 0/3/0", busy, cnt_count, match); end
    endtask

    task automatic test_wrap();
        logic [7:0] exp_cnt [2:5];
        exp_cnt[2] = 8'd254; exp_cnt[3] = 8'd255; exp_cnt[4] = 8'd0; exp_cnt[5] = 8'd1;
        pulse_start(1'b0, 8'd254, 8'd1, 16'd0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            n_compared++; if (cnt_count !== exp_cnt[c] || match !== 1'b0) begin n_mismatched++; $display("[TB] FAIL wrap_c%0d: count %0d match %b want %0d/0", c, cnt_count, match, exp_cnt[c]); end
        end
        tick();
        n_compared++; if (match !== 1'b1 || busy !== 1'b0 || cnt_count !== 8'd1) begin n_mismatched++; $display("[TB] FAIL wrap_done: match %b busy %b count %0d want 1/0/1", match, busy, cnt_count); end
    endtask

    task automatic test_stop_run();
        pulse_start(1'b0, 8'd5, 8'd20, 16'd0);
        tick(); tick(); tick();
        n_compared++; if (cnt_count !== 8'd7) begin n_mismatched++; $display("[TB] FAIL stop_pre: count %0d want 7", cnt_count); end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_compared++; if (busy !== 1'b0 || cnt_count !== 8'd7 || match !== 1'b0 || irq !== 1'b1) begin n_mismatched++; $display("[TB] FAIL stop_run: busy %b count %0d match %b irq %b want 0/7/0/1", busy, cnt_count, match, irq); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_compared++; if (cnt_count !== 8'd7 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL stop_hold[%0d]: count %0d busy %b want 7/0", i, cnt_count, busy); end
        end
    endtask

    task automatic test_start_stop_together();
        pulse_start(1'b0, 8'd5, 8'd20, 16'd0);
        tick(); tick();
        start_value = 8'd100;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_compared++; if (busy !== 1'b0 || cnt_count !== 8'd6) begin n_mismatched++; $display("[TB] FAIL startstop_run: busy %b count %0d want 0/6", busy, cnt_count); end
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        n_compared++; if (busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL startstop_idle: busy %b want 0", busy); end
        tick();
        n_compared++; if (busy !== 1'b0 || cnt_count !== 8'd6) begin n_mismatched++; $display("[TB] FAIL startstop_idle2: busy %b count %0d want 0/6", busy, cnt_count); end
    endtask

    task automatic test_start_during_run();
        pulse_start(1'b0, 8'd5, 8'd8, 16'd0);
        tick();
        start_value = 8'd50; end_value = 8'd60;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_compared++; if (cnt_count !== 8'd6 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL restart_c3: count %0d busy %b want 6/1", cnt_count, busy); end
        tick();
        n_compared++; if (cnt_count !== 8'd7) begin n_mismatched++; $display("[TB] FAIL restart_c4: count %0d want 7", cnt_count); end
        tick();
        n_compared++; if (cnt_count !== 8'd8 || match !== 1'b0) begin n_mismatched++; $display("[TB] FAIL restart_c5: count %0d match %b want 8/0", cnt_count, match); end
        tick();
        n_compared++; if (match !== 1'b1 || busy !== 1'b0 || cnt_count !== 8'd8) begin n_mismatched++; $display("[TB] FAIL restart_done: match %b busy %b count %0d want 1/0/8", match, busy, cnt_count); end
    endtask

    task automatic test_irq();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        n_compared++; if (irq !== 1'b0) begin n_mismatched++; $display("[TB] FAIL irq_clear_alone: irq %b want 0", irq); end
        pulse_start(1'b0, 8'd10, 8'd10, 16'd0);
        tick();
        n_compared++; if (cnt_count !== 8'd10 || irq !== 1'b0) begin n_mismatched++; $display("[TB] FAIL irq_pre: count %0d irq %b want 10/0", cnt_count, irq); end
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
        n_compared++; if (irq !== 1'b1 || match !== 1'b1 || busy !== 1'b0) begin n_mismatched++; $display("[TB] FAIL irq_set_wins: irq %b match %b busy %b want 1/1/0", irq, match, busy); end
        pulse_start(1'b0, 8'd10, 8'd10, 16'd0);
        n_compared++; if (irq !== 1'b1 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL irq_start_keeps: irq %b busy %b want 1/1", irq, busy); end
        tick(); tick();
    endtask

    task automatic test_saturation();
        pulse_start(1'b1, 8'd42, 8'd42, 16'd0);
        for (int c = 2; c <= 302; c++) begin
            tick();
            if (c == 3) begin
                n_compared++; if (period_count !== 8'd1 || match !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sat_c3: period %0d match %b want 1/1", period_count, match); end
            end
            if (c == 256) begin
                n_compared++; if (period_count !== 8'd254) begin n_mismatched++; $display("[TB] FAIL sat_c256: period %0d want 254", period_count); end
            end
            if (c == 257) begin
                n_compared++; if (period_count !== 8'd255) begin n_mismatched++; $display("[TB] FAIL sat_c257: period %0d want 255", period_count); end
            end
        end
        n_compared++; if (period_count !== 8'd255 || cnt_count !== 8'd42 || match !== 1'b1 || busy !== 1'b1) begin n_mismatched++; $display("[TB] FAIL sat_end: period %0d count %0d match %b busy %b want 255/42/1/1", period_count, cnt_count, match, busy); end
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b1;
        #1;
        n_compared++; if (cnt_reset !== 1'b1) begin n_mismatched++; $display("[TB] FAIL midreset_cnt_reset: got %b want 1", cnt_reset); end
        tick();
        reset = 1'b0;
        n_compared++; if (busy !== 1'b0 || cnt_count !== 8'd0 || period_count !== 8'd0 || irq !== 1'b0 || match !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset: busy %b count %0d period %0d irq %b match %b want 0/0/0/0/0", busy, cnt_count, period_count, irq, match); end
        tick();
        n_compared++; if (busy !== 1'b0 || cnt_count !== 8'd0 || match !== 1'b0) begin n_mismatched++; $display("[TB] FAIL midreset_after: busy %b count %0d match %b want 0/0/0", busy, cnt_count, match); end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic_prescale();
        test_wrap();
        test_stop_run();
        test_start_stop_together();
        test_start_during_run();
        test_irq();
        test_saturation();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
